// File: rtl/line_drawer.sv
// Bresenham line engine: latches two endpoints on start and walks pixel by
// pixel toward the framebuffer write port, one pixel per accepting edge.
module line_drawer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         line_reset,
  input  logic         start,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] y0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  output logic         finish,
  output logic         busy,
  output logic         plot,
  output logic [W-1:0] px,
  output logic [W-1:0] py,
  input  logic         plot_ready
);

  typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

  state_t state, state_nx;

  logic                clr;
  logic [W-1:0]        lx0, ly0, lx1, ly1;
  logic [W-1:0]        cx, cy;
  logic [W-1:0]        adx, ady;
  logic signed [W:0]   dx, dy, init_dx, init_dy;
  logic                sx_neg, sy_neg;
  logic signed [W+3:0] dx4, dy4, idx4, idy4, e2;
  logic signed [W+2:0] err, err_nx;
  logic                at_end, accept, step_x, step_y;

  assign clr = reset | line_reset;

  // Magnitudes computed from the latched endpoints so later input changes are ignored
  assign adx     = (lx1 >= lx0) ? lx1 - lx0 : lx0 - lx1;
  assign ady     = (ly1 >= ly0) ? ly1 - ly0 : ly0 - ly1;
  assign init_dx = $signed({1'b0, adx});
  assign init_dy = -$signed({1'b0, ady});

  assign idx4 = {{3{init_dx[W]}}, init_dx};
  assign idy4 = {{3{init_dy[W]}}, init_dy};
  assign dx4  = {{3{dx[W]}}, dx};
  assign dy4  = {{3{dy[W]}}, dy};
  assign e2   = {err, 1'b0};

  assign at_end = (cx == lx1) && (cy == ly1);
  assign accept = (state == DRAW) && plot_ready;
  assign step_x = (e2 >= dy4);
  assign step_y = (e2 <= dx4);

  // Both steps share one e2, so err accumulates dy and dx on a diagonal step
  always_comb begin
    err_nx = err;
    if (step_x) err_nx = err_nx + dy4[W+2:0];
    if (step_y) err_nx = err_nx + dx4[W+2:0];
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = INIT;
      INIT: state_nx = DRAW;
      DRAW: if (plot_ready && at_end) state_nx = DONE;
      DONE: if (!start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    plot   = 1'b0;
    busy   = 1'b0;
    finish = 1'b0;
    case (state)
      INIT: busy = 1'b1;
      DRAW: begin busy = 1'b1; plot = 1'b1; end
      DONE: finish = 1'b1;
      default: ;
    endcase
  end

  assign px = cx;
  assign py = cy;

  always_ff @(posedge clk) begin
    if (clr) begin
      lx0 <= '0; ly0 <= '0; lx1 <= '0; ly1 <= '0;
      cx  <= '0; cy  <= '0;
      dx  <= '0; dy  <= '0; err <= '0;
      sx_neg <= 1'b0; sy_neg <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        lx0 <= x0; ly0 <= y0; lx1 <= x1; ly1 <= y1;
      end
      if (state == INIT) begin
        dx     <= init_dx;
        dy     <= init_dy;
        err    <= idx4[W+2:0] + idy4[W+2:0];
        sx_neg <= (lx1 < lx0);
        sy_neg <= (ly1 < ly0);
        cx     <= lx0;
        cy     <= ly0;
      end
      if (accept && !at_end) begin
        err <= err_nx;
        if (step_x) cx <= sx_neg ? cx - W'(1) : cx + W'(1);
        if (step_y) cy <= sy_neg ? cy - W'(1) : cy + W'(1);
      end
    end
  end

endmodule

// File: tb/tb_line_drawer.sv
// Directed bench for line_drawer: each pixel is checked against a Bresenham
// model, with hand-written pixel lists for the short lines.
module tb_line_drawer;

  localparam int W = 13;

  logic         clk = 1'b0;
  logic         reset = 1'b1, line_reset = 1'b0, start = 1'b0, plot_ready = 1'b0;
  logic [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic         finish, busy, plot;
  logic [W-1:0] px, py;

  int n_chk = 0;
  int n_fail = 0;
  int cap_x [0:255];
  int cap_y [0:255];
  int cap_n;

  line_drawer #(.W(W)) dut (
    .clk(clk), .reset(reset), .line_reset(line_reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .finish(finish), .busy(busy), .plot(plot), .px(px), .py(py),
    .plot_ready(plot_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts a line, walks it against the model, and checks completion timing.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int exp_n, input bit bp);
    int mx, my, mdx, mdy, msx, msy, merr, e2, budget;
    bit done, rdy;
    x0 = W'(ax0); y0 = W'(ay0); x1 = W'(ax1); y1 = W'(ay1);
    start = 1'b1;
    tick();
    chk("init_busy", busy, 1);
    chk("init_plot", plot, 0);
    // Scramble the endpoints: the latched copy must be used
    x0 = W'($urandom); y0 = W'($urandom); x1 = W'($urandom); y1 = W'($urandom);
    tick();
    mx = ax0; my = ay0;
    mdx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    mdy = (ay1 >= ay0) ? ay0 - ay1 : ay1 - ay0;
    msx = (ax1 >= ax0) ? 1 : -1;
    msy = (ay1 >= ay0) ? 1 : -1;
    merr = mdx + mdy;
    cap_n = 0; done = 0; budget = 0;
    while (!done && budget < 20000) begin
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      plot_ready = rdy;
      chk("draw_plot", plot, 1);
      chk("draw_finish", finish, 0);
      chk("px", px, mx);
      chk("py", py, my);
      if (rdy && cap_n < 256) begin
        cap_x[cap_n] = int'(px);
        cap_y[cap_n] = int'(py);
      end
      tick();
      budget++;
      if (rdy) begin
        cap_n++;
        if (mx == ax1 && my == ay1) done = 1;
        else begin
          e2 = 2 * merr;
          if (e2 >= mdy) begin merr += mdy; mx += msx; end
          if (e2 <= mdx) begin merr += mdx; my += msy; end
        end
      end
    end
    plot_ready = 1'b0;
    chk("line_timeout", done, 1);
    chk("pixel_count", cap_n, exp_n);
    chk("done_finish", finish, 1);
    chk("done_busy", busy, 0);
    chk("done_plot", plot, 0);
  endtask

  task automatic end_line();
    start = 1'b0;
    tick();
    chk("end_finish", finish, 0);
    chk("end_busy", busy, 0);
    chk("end_plot", plot, 0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_finish", finish, 0);
    chk("rst_busy", busy, 0);
    chk("rst_plot", plot, 0);
    chk("rst_px", px, 0);
    chk("rst_py", py, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Horizontal, start held through DONE for a few cycles
    run_line(0, 0, 3, 0, 4, 0);
    for (int i = 0; i < 4; i++) begin
      chk("h_x", cap_x[i], i);
      chk("h_y", cap_y[i], 0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h_hold_finish", finish, 1);
      chk("h_hold_plot", plot, 0);
    end
    end_line();

    // Steep reverse line
    run_line(5, 400, 2, 300, 101, 0);
    for (int i = 0; i < 101; i++) chk("steep_y", cap_y[i], 400 - i);
    for (int i = 1; i < 101; i++) chk("steep_x_nonincr", 32'(cap_x[i] <= cap_x[i-1]), 1);
    chk("steep_first_x", cap_x[0], 5);
    chk("steep_last_x", cap_x[100], 2);
    end_line();

    // Single point
    run_line(7, 7, 7, 7, 1, 0);
    chk("pt_x", cap_x[0], 7);
    chk("pt_y", cap_y[0], 7);
    end_line();

    // Backpressure; steps follow the e2 rules with shared e2 per edge
    run_line(0, 0, 4, 2, 5, 1);
    chk("bp_p0", {cap_x[0][15:0], cap_y[0][15:0]}, {16'd0, 16'd0});
    chk("bp_p1", {cap_x[1][15:0], cap_y[1][15:0]}, {16'd1, 16'd1});
    chk("bp_p2", {cap_x[2][15:0], cap_y[2][15:0]}, {16'd2, 16'd1});
    chk("bp_p3", {cap_x[3][15:0], cap_y[3][15:0]}, {16'd3, 16'd2});
    chk("bp_p4", {cap_x[4][15:0], cap_y[4][15:0]}, {16'd4, 16'd2});
    end_line();

    // Software reset during the 10th pixel of (0,0)->(100,0)
    x0 = 0; y0 = 0; x1 = 100; y1 = 0;
    start = 1'b1;
    tick();
    tick();
    plot_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_plot", plot, 1);
    chk("mid_px", px, 9);
    line_reset = 1'b1;
    start = 1'b0;
    tick();
    line_reset = 1'b0;
    plot_ready = 1'b0;
    chk("lr_plot", plot, 0);
    chk("lr_busy", busy, 0);
    chk("lr_finish", finish, 0);
    chk("lr_px", px, 0);
    tick();
    chk("lr_idle_busy", busy, 0);
    run_line(2, 3, 5, 1, 4, 0);
    chk("lr_first_x", cap_x[0], 2);
    chk("lr_first_y", cap_y[0], 3);
    chk("lr_last_x", cap_x[3], 5);
    chk("lr_last_y", cap_y[3], 1);
    end_line();

    // Full-range diagonal; start held high in DONE must not restart
    run_line(0, 0, 8191, 8191, 8192, 0);
    chk("full_px", px, 8191);
    chk("full_py", py, 8191);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_hold_finish", finish, 1);
      chk("full_hold_busy", busy, 0);
    end
    end_line();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
